// File: rtl/datawidthconv_arbiter_if.sv
// Stream bundle between two packet requesters, the arbiter and the
// 512-to-32 width converter it feeds.
// slave  : arbiter view (consumes s0/s1, produces snk)
// master : environment view (produces s0/s1, consumes snk)
interface datawidthconv_arbiter_if #(
    parameter int DATA_W = 512
);
    logic              s0_sop;
    logic              s0_eop;
    logic              s0_valid;
    logic [DATA_W-1:0] s0_din;
    logic              s0_ready;

    logic              s1_sop;
    logic              s1_eop;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_din;
    logic              s1_ready;

    logic              snk_sop;
    logic              snk_eop;
    logic              snk_valid;
    logic [DATA_W-1:0] snk_din;

    modport slave (
        input  s0_sop, s0_eop, s0_valid, s0_din,
        output s0_ready,
        input  s1_sop, s1_eop, s1_valid, s1_din,
        output s1_ready,
        output snk_sop, snk_eop, snk_valid, snk_din
    );

    modport master (
        output s0_sop, s0_eop, s0_valid, s0_din,
        input  s0_ready,
        output s1_sop, s1_eop, s1_valid, s1_din,
        input  s1_ready,
        input  snk_sop, snk_eop, snk_valid, snk_din
    );
endinterface

// File: rtl/datawidthconv_arbiter.sv
// Two-requester packet arbiter in front of a 512-to-32 width converter.
// A granted requester owns the sink until its EOP beat is forwarded; the
// sink is then held idle for DRAIN_CYCLES cycles so the converter can
// empty before the next packet. Ties in IDLE are broken round-robin.
// Optional feature (macro DWC_ARB_LENCHK_EN): beats 33 and later of a
// packet are swallowed (an EOP among them still goes out as an eop-only
// beat) and the sticky err_overlen flag is raised.
module datawidthconv_arbiter #(
    parameter int DRAIN_CYCLES = 520
) (
    input  logic                          clk,
    input  logic                          reset_n,
    datawidthconv_arbiter_if.slave        bus,
    output logic                          owner,
    output logic                          busy,
    output logic                          done
`ifdef DWC_ARB_LENCHK_EN
    ,
    output logic                          err_overlen
`endif
);
    localparam int DATA_W = 512;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant_vld;
    logic              grant_idx;
    logic              req0;
    logic              req1;
    logic              in_grant;
    logic              accept;
    logic              beat_sop;
    logic              beat_eop;
    logic [DATA_W-1:0] beat_din;
    logic              drain_end;
    logic [15:0]       drain_cnt;
    logic              vld_p0;
    logic              sop_p0;

    assign req0     = bus.s0_valid & bus.s0_sop;
    assign req1     = bus.s1_valid & bus.s1_sop;
    assign in_grant = (state == GRANT);

    // Only the owner's lane is ever looked at while a packet is in flight.
    assign beat_sop = owner ? bus.s1_sop : bus.s0_sop;
    assign beat_eop = owner ? bus.s1_eop : bus.s0_eop;
    assign beat_din = owner ? bus.s1_din : bus.s0_din;
    assign accept   = in_grant & (owner ? bus.s1_valid : bus.s0_valid);

    assign bus.s0_ready = in_grant & ~owner;
    assign bus.s1_ready = in_grant &  owner;
    assign busy         = (state != IDLE);

    // The decrement that reaches zero is the one that leaves DRAIN.
    assign drain_end = (state == DRAIN) && (drain_cnt == 16'd1);

    // Next-state and grant selection.
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_idx = owner;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    grant_vld = 1'b1;
                    grant_idx = (req0 & req1) ? ~owner : req1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (accept && beat_eop) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner tracking, drain countdown and the completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= 1'b1;
            drain_cnt <= 16'd0;
            done      <= 1'b0;
        end else begin
            done <= drain_end;
            if (grant_vld) begin
                owner <= grant_idx;
            end
            if (accept && beat_eop) begin
                drain_cnt <= 16'(DRAIN_CYCLES);
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - 16'd1;
            end
        end
    end

`ifdef DWC_ARB_LENCHK_EN
    logic [5:0] beat_cnt;
    logic [5:0] beat_num;
    logic       drop;
    logic       err_q;

    // Position of the current beat in its packet, saturating at 33.
    always_comb begin
        beat_num = 6'd1;
        if (!beat_sop) begin
            beat_num = (beat_cnt >= 6'd33) ? 6'd33 : beat_cnt + 6'd1;
        end
    end

    assign drop   = accept && (beat_num >= 6'd33);
    assign vld_p0 = accept & (~drop | beat_eop);
    assign sop_p0 = beat_sop & ~drop;
    assign err_overlen = err_q;

    // Beat count and sticky overlength flag, both restarted on grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt <= 6'd0;
            err_q    <= 1'b0;
        end else if (grant_vld) begin
            beat_cnt <= 6'd0;
            err_q    <= 1'b0;
        end else if (accept) begin
            beat_cnt <= beat_num;
            if (drop) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign vld_p0 = accept;
    assign sop_p0 = beat_sop;
`endif

    // Sink register: accepted beats appear exactly one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.snk_valid <= 1'b0;
            bus.snk_sop   <= 1'b0;
            bus.snk_eop   <= 1'b0;
            bus.snk_din   <= '0;
        end else begin
            bus.snk_valid <= vld_p0;
            bus.snk_sop   <= vld_p0 & sop_p0;
            bus.snk_eop   <= vld_p0 & beat_eop;
            if (vld_p0) begin
                bus.snk_din <= beat_din;
            end
        end
    end
endmodule

// File: tb/tb_datawidthconv_arbiter.sv
// Bench for datawidthconv_arbiter: drives both requesters, keeps a queue of
// the beats the sink must show and compares them as they come out.
module tb_datawidthconv_arbiter;
    localparam int DRAIN = 520;

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [511:0] din;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic owner, busy, done;
`ifdef DWC_ARB_LENCHK_EN
    logic err_overlen;
`endif

    datawidthconv_arbiter_if bus ();

    datawidthconv_arbiter #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .owner       (owner),
        .busy        (busy),
        .done        (done)
`ifdef DWC_ARB_LENCHK_EN
        ,
        .err_overlen (err_overlen)
`endif
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    eop_cyc = 0;
    int    done_cyc = 0;
    int    done_cnt = 0;
    int    eop_cnt = 0;
    int    fwd_cnt = 0;
    int    model_n = 0;
    logic  prev_done = 1'b0;
    beat_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected sink beat for an accepted input beat.
    task automatic model_accept(input logic sop, input logic eop, input logic [511:0] din);
        beat_t b;
        model_n = sop ? 1 : ((model_n >= 33) ? 33 : model_n + 1);
        b.sop = sop;
        b.eop = eop;
        b.din = din;
`ifdef DWC_ARB_LENCHK_EN
        if (model_n >= 33) begin
            if (eop) begin
                b.sop = 1'b0;
                sb.push_back(b);
            end
        end else begin
            sb.push_back(b);
        end
`else
        sb.push_back(b);
`endif
    endtask

    // Monitor: sink comparison, done bookkeeping, push of accepted beats.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            model_n = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.snk_valid) begin
                fwd_cnt++;
                if (bus.snk_eop) begin
                    eop_cyc = cyc;
                    eop_cnt++;
                end
                if (sb.size() == 0) begin
                    chk("snk_unexpected_beat", 512'(1), 512'(0));
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("snk_sop", 512'(bus.snk_sop), 512'(e.sop));
                    chk("snk_eop", 512'(bus.snk_eop), 512'(e.eop));
                    chk("snk_din", bus.snk_din, e.din);
                end
            end
            if (sb.size() != 0) begin
                chk("snk_beat_missing", 512'(sb.size()), 512'(0));
                sb.delete();
            end
            if (done) begin
                if (prev_done) chk("done_one_cycle", 512'(1), 512'(0));
                done_cyc = cyc;
                done_cnt++;
            end
            prev_done = done;
            if (bus.s0_ready && bus.s1_ready) chk("both_ready", 512'(1), 512'(0));
            if (bus.s0_valid && bus.s0_ready) model_accept(bus.s0_sop, bus.s0_eop, bus.s0_din);
            else if (bus.s1_valid && bus.s1_ready) model_accept(bus.s1_sop, bus.s1_eop, bus.s1_din);
        end
    end

    task automatic drive(input bit r, input logic v, input logic s, input logic e,
                         input logic [511:0] d);
        if (!r) begin
            bus.s0_valid = v; bus.s0_sop = s; bus.s0_eop = e; bus.s0_din = d;
        end else begin
            bus.s1_valid = v; bus.s1_sop = s; bus.s1_eop = e; bus.s1_din = d;
        end
    endtask

    // Sends a packet on requester r; abort_after>0 stops after that many beats.
    task automatic send_packet(input bit r, input int nbeats, input int abort_after,
                               output int first_acc);
        logic [511:0] d;
        first_acc = -1;
        for (int b = 0; b < nbeats; b++) begin
            int  t;
            bit  acc;
            if (nbeats == 1) d = {64{8'hA5}};
            else for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
            drive(r, 1'b1, b == 0, b == nbeats - 1, d);
            t = 0;
            acc = 0;
            while (!acc && t < 3000) begin
                @(negedge clk);
                if (r ? bus.s1_ready : bus.s0_ready) acc = 1;
                t++;
            end
            if (!acc) begin
                chk("accept_timeout", 512'(0), 512'(1));
                drive(r, 1'b0, 1'b0, 1'b0, '0);
                return;
            end
            if (b == 0) first_acc = cyc;
            @(posedge clk);
            #1;
            if (abort_after != 0 && b + 1 == abort_after) begin
                drive(r, 1'b0, 1'b0, 1'b0, '0);
                return;
            end
        end
        drive(r, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic wait_done();
        int start;
        int t;
        start = done_cnt;
        t = 0;
        while (done_cnt == start && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == start) chk("done_timeout", 512'(0), 512'(1));
        else chk("drain_length", 512'(done_cyc - eop_cyc), 512'(DRAIN));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_snk_valid"}, 512'(bus.snk_valid), 512'(0));
        chk({tag, "_snk_sop"}, 512'(bus.snk_sop), 512'(0));
        chk({tag, "_snk_eop"}, 512'(bus.snk_eop), 512'(0));
        chk({tag, "_snk_din"}, bus.snk_din, 512'(0));
        chk({tag, "_s0_ready"}, 512'(bus.s0_ready), 512'(0));
        chk({tag, "_s1_ready"}, 512'(bus.s1_ready), 512'(0));
        chk({tag, "_owner"}, 512'(owner), 512'(1));
        chk({tag, "_busy"}, 512'(busy), 512'(0));
        chk({tag, "_done"}, 512'(done), 512'(0));
`ifdef DWC_ARB_LENCHK_EN
        chk({tag, "_err_overlen"}, 512'(err_overlen), 512'(0));
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check_reset_values("rst");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0, fa0, fa1, f0;
        drive(0, 1'b0, 1'b0, 1'b0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("por");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // 32-beat packet on requester 0.
        @(posedge clk); #1;
        c0 = cyc; f0 = fwd_cnt;
        send_packet(0, 32, 0, fa0);
        chk("a_grant_latency", 512'(fa0), 512'(c0 + 1));
        chk("a_busy_drain", 512'(busy), 512'(1));
        wait_done();
        chk("a_fwd_count", 512'(fwd_cnt - f0), 512'(32));
        chk("a_owner", 512'(owner), 512'(0));
        chk("a_busy_idle", 512'(busy), 512'(0));

        // Single-beat packet with the A5 pattern on requester 1.
        @(posedge clk); #1;
        f0 = fwd_cnt;
        send_packet(1, 1, 0, fa1);
        chk("b_busy_drain", 512'(busy), 512'(1));
        wait_done();
        chk("b_fwd_count", 512'(fwd_cnt - f0), 512'(1));
        chk("b_owner", 512'(owner), 512'(1));

        // Simultaneous requests straight after reset.
        do_reset();
        fork
            send_packet(0, 4, 0, fa0);
            send_packet(1, 3, 0, fa1);
        join
        chk("c_r0_first", 512'(fa0 < fa1), 512'(1));
        chk("c_r1_after_done", 512'(fa1), 512'(done_cyc + 1));
        wait_done();
        chk("c_owner", 512'(owner), 512'(1));

        // Requester 1 arrives during requester 0's drain.
        @(posedge clk); #1;
        fork
            send_packet(0, 3, 0, fa0);
            begin
                int t, e0;
                e0 = eop_cnt;
                t = 0;
                while (eop_cnt == e0 && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
                send_packet(1, 2, 0, fa1);
            end
        join
        chk("d_r1_after_done", 512'(fa1), 512'(done_cyc + 1));
        wait_done();

        // Reset in the middle of a 32-beat packet, then a clean packet.
        @(posedge clk); #1;
        send_packet(0, 32, 10, fa0);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values("mid");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        send_packet(0, 4, 0, fa0);
        chk("e_grant_latency", 512'(fa0), 512'(c0 + 1));
        wait_done();
        chk("e_owner", 512'(owner), 512'(0));

        // 34-beat packet on requester 1.
        @(posedge clk); #1;
        f0 = fwd_cnt;
        send_packet(1, 34, 0, fa1);
        wait_done();
`ifdef DWC_ARB_LENCHK_EN
        chk("f_fwd_count", 512'(fwd_cnt - f0), 512'(33));
        chk("f_err_set", 512'(err_overlen), 512'(1));
`else
        chk("f_fwd_count", 512'(fwd_cnt - f0), 512'(34));
`endif
        @(posedge clk); #1;
        send_packet(0, 2, 0, fa0);
`ifdef DWC_ARB_LENCHK_EN
        chk("f_err_cleared", 512'(err_overlen), 512'(0));
`endif
        wait_done();

        @(negedge clk);
        chk("sb_empty", 512'(sb.size()), 512'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/datawidthconv_arbiter.md
DATAWIDTHCONV_ARBITER -- requirements
Module: datawidthconv_arbiter

Interface
REQ-001 Parameter DRAIN_CYCLES, default 520: idle cycles held after a forwarded end-of-packet (EOP) while the 512-to-32 converter drains; legal range 1..65535.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-004 s0_sop, s0_eop, s0_valid  input  1 each  requester 0 stream controls.
REQ-005 s0_din  input  512  requester 0 beat data.
REQ-006 s0_ready  output  1  requester 0 beat accepted when s0_valid & s0_ready.
REQ-007 s1_sop, s1_eop, s1_valid, s1_din, s1_ready: same as REQ-004..006 for requester 1.
REQ-008 snk_sop, snk_eop, snk_valid  output  1 each  registered stream to the converter.
REQ-009 snk_din  output  512  registered beat data to the converter.
REQ-010 owner  output  1  index of the currently or last granted requester.
REQ-011 busy  output  1  high in GRANT and DRAIN.
REQ-012 done  output  1  one-cycle pulse when DRAIN completes.
REQ-013 err_overlen  output  1  sticky overlength flag; exists only with the macro.

Function
REQ-014 States: IDLE, GRANT, DRAIN.
REQ-015 Request i = si_valid & si_sop; a requester holds its first beat stable until it is accepted.
REQ-016 IDLE, one request: grant that requester, set owner, and enter GRANT next cycle.
REQ-017 IDLE, both requests: grant the requester not equal to owner (round-robin); after reset owner=1, so requester 0 wins the first tie.
REQ-018 GRANT: si_ready = 1 only for the owner; the other ready is 0; both readies are 0 in IDLE and DRAIN.
REQ-019 Each accepted beat appears on snk_* exactly 1 cycle later with sop, eop and din unchanged and snk_valid=1; otherwise snk_valid=0.
REQ-020 Beats with valid low in GRANT are bubbles; nothing is forwarded and the state holds.
REQ-021 Accepted beat with eop=1: enter DRAIN next cycle and load the drain counter with DRAIN_CYCLES.
REQ-022 Accepted beat with sop=1 and eop=1 (single-beat packet): forward it, then DRAIN.
REQ-023 sop=1 on a later beat within a packet: forward it and restart the beat count at 1.
REQ-024 DRAIN: decrement the counter each cycle; at 0 go to IDLE with done=1 in that same cycle.
REQ-025 Total converter lockout after the EOP beat is forwarded = DRAIN_CYCLES cycles.
REQ-026 Requests arriving during GRANT or DRAIN wait; no beat is lost, because ready=0.
REQ-027 Beat counter: 6 bits, saturates at 33, cleared on grant.

Reset
REQ-028 On reset_n low: state=IDLE, s0_ready=s1_ready=0, snk_sop=snk_eop=snk_valid=0, snk_din=0, owner=1, busy=0, done=0, err_overlen=0, counters=0.
REQ-029 Reset mid-packet: abandon the packet immediately; no partial EOP is generated.

Configuration
REQ-030 Macro DWC_ARB_LENCHK_EN defined: beats 33 and later of a packet are accepted but not forwarded.
REQ-031 DWC_ARB_LENCHK_EN defined: err_overlen sets on the first dropped beat and clears on the next grant.
REQ-032 DWC_ARB_LENCHK_EN defined: an EOP on a dropped beat still causes DRAIN and forwards a single beat with snk_eop=1, snk_sop=0 and that beat's din.
REQ-033 DWC_ARB_LENCHK_EN undefined: all beats are forwarded, the err_overlen port is absent, and no length logic is present.

Verification
REQ-034 Requester 0 sends a 32-beat packet, DRAIN_CYCLES=520 -> 32 snk beats, each 1 cycle after acceptance; done pulses 520 cycles after the EOP beat is forwarded; owner=0.
REQ-035 Both requesters raise sop in the same IDLE cycle after reset -> requester 0 is granted first; requester 1 is granted in the first IDLE cycle after done.
REQ-036 Requester 1 raises a request during requester 0's DRAIN -> s1_ready stays 0 until DRAIN ends; its beat is then forwarded intact.
REQ-037 Single beat with sop=eop=1, din=0xA5...A5 -> one snk beat with sop=eop=1 and identical din; DRAIN follows.
REQ-038 reset_n pulsed low at beat 10 of 32 -> all outputs go to reset values immediately; the next packet starts cleanly from IDLE.
REQ-039 With DWC_ARB_LENCHK_EN, 34-beat packet -> beats 1..32 forwarded unchanged, beat 33 dropped, beat 34 forwarded as eop-only, err_overlen=1 until the next grant.
